extensor_imediato: RTL and testbench

Parametrised, registered immediate extender: the next-generation replacement for the fixed 16→32 sign extender in the processor datapath. It widens an IN_W-bit immediate to OUT_W bits in one of four modes (sign, zero, sign-and-shift-by-2, upper placement). A valid/ready handshake with a 2-entry skid buffer sits between the decode stage and the ALU/branch-address operand path, so downstream stalls never drop or duplicate an immediate.

---
 rtl/extensor_pkg.sv | 16 +
 rtl/extensor_modo.sv | 49 ++++
 rtl/extensor_imediato.sv | 86 ++++++++
 tb/tb_extensor_imediato.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/extensor_pkg.sv
// Shared constants for the immediate extender: mode codes and buffer occupancy.
// Mode 2 shifting is enabled only when EXTENSOR_SHIFT_EN is defined.
package extensor_pkg;

  localparam logic [1:0] MODO_SINAL    = 2'd0;
  localparam logic [1:0] MODO_ZERO     = 2'd1;
  localparam logic [1:0] MODO_DESLOC   = 2'd2;
  localparam logic [1:0] MODO_SUPERIOR = 2'd3;

  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    CHEIO = 2'd1,
    SKID  = 2'd2
  } estado_t;

endpackage

// File: rtl/extensor_modo.sv
// Combinational mode logic: widens sinal_in to OUT_W bits per modo.
// With EXTENSOR_SHIFT_EN undefined, mode 2 falls back to plain sign extension.
module extensor_modo
  import extensor_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  sinal_in,
  input  logic [1:0]       modo,
  output logic [OUT_W-1:0] resultado
);

  logic [OUT_W-1:0] ext_sinal;
  logic [OUT_W-1:0] ext_zero;
  logic [OUT_W-1:0] ext_sup;

  assign ext_sinal = {{(OUT_W-IN_W){sinal_in[IN_W-1]}}, sinal_in};
  assign ext_zero  = {{(OUT_W-IN_W){1'b0}}, sinal_in};
  assign ext_sup   = {sinal_in, {(OUT_W-IN_W){1'b0}}};

`ifdef EXTENSOR_SHIFT_EN
  logic [OUT_W-1:0] ext_desloc;

  // Top two bits of the sign-extended value fall off the end
  assign ext_desloc = {ext_sinal[OUT_W-3:0], 2'b00};

  always_comb begin
    resultado = ext_sinal;
    unique case (modo)
      MODO_SINAL:    resultado = ext_sinal;
      MODO_ZERO:     resultado = ext_zero;
      MODO_DESLOC:   resultado = ext_desloc;
      MODO_SUPERIOR: resultado = ext_sup;
    endcase
  end
`else
  always_comb begin
    resultado = ext_sinal;
    unique case (modo)
      MODO_SINAL:    resultado = ext_sinal;
      MODO_ZERO:     resultado = ext_zero;
      MODO_DESLOC:   resultado = ext_sinal;
      MODO_SUPERIOR: resultado = ext_sup;
    endcase
  end
`endif

endmodule

// File: rtl/extensor_imediato.sv
// Registered immediate extender with a 2-entry skid buffer on a valid/ready link.
// Mode behaviour lives in extensor_modo (EXTENSOR_SHIFT_EN gates mode 2 shifting).
module extensor_imediato
  import extensor_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  sinal_in,
  input  logic [1:0]       modo,
  input  logic             valido_in,
  output logic             pronto_in,
  output logic [OUT_W-1:0] sinal_out,
  output logic             valido_out,
  input  logic             pronto_out
);

  estado_t          estado, estado_n;
  logic [OUT_W-1:0] r, r_n;
  logic [OUT_W-1:0] s, s_n;
  logic [OUT_W-1:0] resultado;
  logic             entra, sai;

  extensor_modo #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_modo (
    .sinal_in  (sinal_in),
    .modo      (modo),
    .resultado (resultado)
  );

  // Ready depends on registered occupancy only
  assign pronto_in  = (estado != SKID);
  assign valido_out = (estado != VAZIO);
  assign sinal_out  = r;

  assign entra = valido_in && pronto_in;
  assign sai   = valido_out && pronto_out;

  always_comb begin
    estado_n = estado;
    r_n      = r;
    s_n      = s;
    unique case (estado)
      VAZIO: begin
        if (entra) begin
          r_n      = resultado;
          estado_n = CHEIO;
        end
      end
      CHEIO: begin
        if (entra && !sai) begin
          s_n      = resultado;
          estado_n = SKID;
        end else if (sai && !entra) begin
          estado_n = VAZIO;
        end else if (entra && sai) begin
          r_n = resultado;
        end
      end
      SKID: begin
        if (sai) begin
          r_n      = s;
          estado_n = CHEIO;
        end
      end
      default: estado_n = VAZIO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= VAZIO;
      r      <= '0;
      s      <= '0;
    end else begin
      estado <= estado_n;
      r      <= r_n;
      s      <= s_n;
    end
  end

endmodule

// File: tb/tb_extensor_imediato.sv
// Scoreboard bench for extensor_imediato: directed cases plus random handshakes.
// Expected mode-2 results follow EXTENSOR_SHIFT_EN as the DUT build does.
module tb_extensor_imediato;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic             clock;
  logic             reset;
  logic [IN_W-1:0]  sinal_in;
  logic [1:0]       modo;
  logic             valido_in;
  logic             pronto_in;
  logic [OUT_W-1:0] sinal_out;
  logic             valido_out;
  logic             pronto_out;

  int checks = 0;
  int passed = 0;
  int n_out  = 0;
  logic [OUT_W-1:0] sb[$];

  extensor_imediato #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sinal_in   (sinal_in),
    .modo       (modo),
    .valido_in  (valido_in),
    .pronto_in  (pronto_in),
    .sinal_out  (sinal_out),
    .valido_out (valido_out),
    .pronto_out (pronto_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nome,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nome, act, exp);
  endtask

  // Arithmetic reference: treat the immediate as an integer, scale it,
  // then reduce modulo 2**OUT_W.
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] x,
                                             input logic [1:0] m);
    longint v, res, full;
    full = longint'(1) << OUT_W;
    v = longint'(x);
    if ((m == 2'd0 || m == 2'd2) && x[IN_W-1])
      v = v - (longint'(1) << IN_W);
    case (m)
      2'd0, 2'd1: res = v;
`ifdef EXTENSOR_SHIFT_EN
      2'd2: res = v * 4;
`else
      2'd2: res = v;
`endif
      default: res = v * (longint'(1) << (OUT_W - IN_W));
    endcase
    res = ((res % full) + full) % full;
    return res[OUT_W-1:0];
  endfunction

  // Monitor: the queue mirrors what the DUT should be holding
  always @(negedge clock) begin
    logic [OUT_W-1:0] e;
    if (reset) begin
      sb.delete();
    end else begin
      chk("occ_valido", valido_out, sb.size() > 0);
      chk("occ_pronto", pronto_in, sb.size() < 2);
      if (valido_out && pronto_out) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("dup_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("dado", sinal_out, e);
        end
      end
      if (valido_in && pronto_in)
        sb.push_back(model(sinal_in, modo));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] x, input logic [1:0] m);
    logic acc;
    acc = 1'b0;
    sinal_in  = x;
    modo      = m;
    valido_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      acc = pronto_in;
      tick();
      if (acc) break;
    end
    valido_in = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    reset      = 1'b1;
    valido_in  = 1'b0;
    pronto_out = 1'b1;
    sinal_in   = '0;
    modo       = 2'd0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_valido", valido_out, 0);
    chk("rst_pronto", pronto_in, 1);
    chk("rst_sinal", sinal_out, 0);
    tick();

    send(16'h5555, 2'd0);
    send(16'hFD55, 2'd0);
    send(16'hFD55, 2'd1);
    send(16'h1234, 2'd3);
    send(16'hFFFF, 2'd2);
    send(16'h7FFF, 2'd2);
    repeat (3) tick();

    // Back-pressure: A and B fill the buffer, C is held off
    pronto_out = 1'b0;
    send(16'h0A0A, 2'd0);
    send(16'h0B0B, 2'd1);
    sinal_in  = 16'h8C0C;
    modo      = 2'd3;
    valido_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("hold_pronto", pronto_in, 0);
      chk("hold_sinal", sinal_out, model(16'h0A0A, 2'd0));
      tick();
    end
    pronto_out = 1'b1;
    @(negedge clock);
    chk("nogap0", valido_out, 1);
    chk("nogap0_pronto", pronto_in, 0);
    tick();
    @(negedge clock);
    chk("nogap1", valido_out, 1);
    chk("nogap1_pronto", pronto_in, 1);
    tick();
    valido_in = 1'b0;
    @(negedge clock);
    chk("nogap2", valido_out, 1);
    tick();
    repeat (2) tick();

    // Reset while in SKID, with a valid input presented on the reset edge
    pronto_out = 1'b0;
    send(16'h1D1D, 2'd0);
    send(16'h1E1E, 2'd3);
    sinal_in  = 16'h1F1F;
    modo      = 2'd1;
    valido_in = 1'b1;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    valido_in = 1'b0;
    @(negedge clock);
    chk("rskid_valido", valido_out, 0);
    chk("rskid_pronto", pronto_in, 1);
    chk("rskid_sinal", sinal_out, 0);
    tick();
    pronto_out = 1'b1;
    base = n_out;
    send(16'h2A2A, 2'd1);
    repeat (4) tick();
    chk("rskid_alone", n_out - base, 1);

    for (int i = 0; i < 1000; i++) begin
      valido_in  = ($urandom % 4) != 0;
      sinal_in   = IN_W'($urandom);
      modo       = 2'($urandom);
      pronto_out = ($urandom % 3) != 0;
      reset      = ($urandom % 250) == 0;
      tick();
    end
    reset      = 1'b0;
    valido_in  = 1'b0;
    pronto_out = 1'b1;
    repeat (4) tick();
    chk("drain", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
